// File: rtl/fpu_dispatch_sequencer_if.sv
// CPU/BIU/FPU-facing signal bundle for the ESC dispatch sequencer.
// slave is the sequencer side, master the surrounding core/FPU side.
interface fpu_dispatch_sequencer_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [7:0]  issue_opcode;
  logic [7:0]  issue_modrm;
  logic [5:0]  issue_attr;
  logic        opnd_valid;
  logic [79:0] opnd_data;
  logic        res_valid;
  logic [79:0] res_data;
  logic        res_accept;
  logic        fwait_req;
  logic        seq_error;
  logic        cpu_fpu_instr_valid;
  logic [7:0]  cpu_fpu_opcode;
  logic [7:0]  cpu_fpu_modrm;
  logic        cpu_fpu_has_memory_op;
  logic [1:0]  cpu_fpu_operand_size;
  logic        cpu_fpu_is_integer;
  logic        cpu_fpu_is_bcd;
  logic        cpu_fpu_instr_ack;
  logic        cpu_fpu_data_write;
  logic        cpu_fpu_data_read;
  logic [2:0]  cpu_fpu_data_size;
  logic [79:0] cpu_fpu_data_in;
  logic [79:0] cpu_fpu_data_out;
  logic        cpu_fpu_data_ready;
  logic        cpu_fpu_busy;
  logic        cpu_fpu_ready;
  logic        cpu_fpu_wait;
  logic        cpu_fpu_exception;

  modport slave (
    input  issue_valid, issue_opcode, issue_modrm, issue_attr,
    input  opnd_valid, opnd_data, res_accept, fwait_req,
    input  cpu_fpu_instr_ack, cpu_fpu_data_out, cpu_fpu_data_ready,
    input  cpu_fpu_busy, cpu_fpu_ready, cpu_fpu_exception,
    output issue_ready, res_valid, res_data, seq_error,
    output cpu_fpu_instr_valid, cpu_fpu_opcode, cpu_fpu_modrm,
    output cpu_fpu_has_memory_op, cpu_fpu_operand_size,
    output cpu_fpu_is_integer, cpu_fpu_is_bcd,
    output cpu_fpu_data_write, cpu_fpu_data_read, cpu_fpu_data_size,
    output cpu_fpu_data_in, cpu_fpu_wait
  );

  modport master (
    output issue_valid, issue_opcode, issue_modrm, issue_attr,
    output opnd_valid, opnd_data, res_accept, fwait_req,
    output cpu_fpu_instr_ack, cpu_fpu_data_out, cpu_fpu_data_ready,
    output cpu_fpu_busy, cpu_fpu_ready, cpu_fpu_exception,
    input  issue_ready, res_valid, res_data, seq_error,
    input  cpu_fpu_instr_valid, cpu_fpu_opcode, cpu_fpu_modrm,
    input  cpu_fpu_has_memory_op, cpu_fpu_operand_size,
    input  cpu_fpu_is_integer, cpu_fpu_is_bcd,
    input  cpu_fpu_data_write, cpu_fpu_data_read, cpu_fpu_data_size,
    input  cpu_fpu_data_in, cpu_fpu_wait
  );
endinterface

// File: rtl/fpu_dispatch_sequencer.sv
// Sequences decoded ESC instructions, operands, store results and
// FWAIT between the CPU core, the BIU and the FPU interface.
module fpu_dispatch_sequencer #(
  parameter int ACK_TIMEOUT = 255
) (
  input logic                    clk,
  input logic                    reset_n,
  fpu_dispatch_sequencer_if.slave bus
);
  localparam int CW = (ACK_TIMEOUT > 255) ? $clog2(ACK_TIMEOUT + 1) : 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND   = 3'd1;
  localparam logic [2:0] S_OPND   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;
  localparam logic [2:0] S_READ   = 3'd5;
  localparam logic [2:0] S_HOLD   = 3'd6;
  localparam logic [2:0] S_FWAIT  = 3'd7;

  logic [2:0]    r_state;
  logic [2:0]    w_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [7:0]    r_op;
  logic [7:0]    r_modrm;
  logic [5:0]    r_attr;
  logic [79:0]   r_din;
  logic [79:0]   r_res;
  logic          w_cnt_en;
  logic          w_to;
  logic          w_abort;

  assign w_cnt_en = (r_state == S_SEND) || (r_state == S_RESULT) ||
                    (r_state == S_FWAIT);
  assign w_to     = w_cnt_en && (r_cnt == CW'(ACK_TIMEOUT - 1));

  always_comb begin
    w_nxt   = r_state;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.issue_valid)    w_nxt = S_SEND;
        else if (bus.fwait_req) w_nxt = S_FWAIT;
      end
      S_SEND: begin
        if (bus.cpu_fpu_instr_ack) begin
          if (r_attr[0])      w_nxt = S_OPND;
          else if (r_attr[5]) w_nxt = S_RESULT;
          else                w_nxt = S_IDLE;
        end else if (w_to) begin
          w_nxt   = S_IDLE;
          w_abort = 1'b1;
        end
      end
      S_OPND:  if (bus.opnd_valid) w_nxt = S_WRITE;
      S_WRITE: w_nxt = S_IDLE;
      S_RESULT: begin
        if (bus.cpu_fpu_data_ready) begin
          w_nxt = S_READ;
        end else if (w_to) begin
          w_nxt   = S_IDLE;
          w_abort = 1'b1;
        end
      end
      S_READ:  w_nxt = S_HOLD;
      S_HOLD:  if (bus.res_accept) w_nxt = S_IDLE;
      S_FWAIT: begin
        // An unmasked exception releases the core without waiting.
        if (bus.cpu_fpu_exception ||
            (bus.cpu_fpu_ready && !bus.cpu_fpu_busy)) begin
          w_nxt = S_IDLE;
        end else if (w_to) begin
          w_nxt   = S_IDLE;
          w_abort = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_op    <= '0;
      r_modrm <= '0;
      r_attr  <= '0;
      r_din   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_nxt;
      r_err   <= w_abort;
      if (w_cnt_en && (w_nxt == r_state)) r_cnt <= r_cnt + 1'b1;
      else                               r_cnt <= '0;
      if ((r_state == S_IDLE) && bus.issue_valid) begin
        r_op    <= bus.issue_opcode;
        r_modrm <= bus.issue_modrm;
        r_attr  <= bus.issue_attr;
      end
      if ((r_state == S_OPND) && bus.opnd_valid) r_din <= bus.opnd_data;
      if (r_state == S_READ) r_res <= bus.cpu_fpu_data_out;
    end
  end

  assign bus.issue_ready           = (r_state == S_IDLE);
  assign bus.cpu_fpu_instr_valid   = (r_state == S_SEND);
  assign bus.cpu_fpu_data_write    = (r_state == S_WRITE);
  assign bus.cpu_fpu_data_read     = (r_state == S_READ);
  assign bus.res_valid             = (r_state == S_HOLD);
  assign bus.cpu_fpu_wait          = (r_state == S_FWAIT);
  assign bus.seq_error             = r_err;
  assign bus.res_data              = r_res;
  assign bus.cpu_fpu_data_in       = r_din;
  assign bus.cpu_fpu_opcode        = r_op;
  assign bus.cpu_fpu_modrm         = r_modrm;
  assign bus.cpu_fpu_has_memory_op = r_attr[0];
  assign bus.cpu_fpu_operand_size  = r_attr[2:1];
  assign bus.cpu_fpu_is_integer    = r_attr[3];
  assign bus.cpu_fpu_is_bcd        = r_attr[4];
  assign bus.cpu_fpu_data_size     = r_attr[4] ? 3'd4 : {1'b0, r_attr[2:1]};
endmodule

// File: tb/tb_fpu_dispatch_sequencer.sv
// Scoreboard bench for fpu_dispatch_sequencer: directed ESC, store,
// FWAIT, timeout and reset scenarios.
module tb_fpu_dispatch_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fpu_dispatch_sequencer_if b1 ();
  fpu_dispatch_sequencer_if b2 ();

  fpu_dispatch_sequencer #(.ACK_TIMEOUT(255)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(b1)
  );
  fpu_dispatch_sequencer #(.ACK_TIMEOUT(4)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(b2)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_wr  = 0;
  int n_rd  = 0;
  logic [87:0] q_instr[$];
  logic [87:0] q_wr[$];
  logic [87:0] q_res[$];

  task automatic chk(string nm, logic [87:0] act, logic [87:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [87:0] instr_exp(logic [7:0] op, logic [7:0] m,
                                            logic [5:0] a);
    return 88'({op, m, a[0], a[2:1], a[3], a[4]});
  endfunction

  task automatic zero_inputs;
    b1.issue_valid = 0; b1.issue_opcode = 0; b1.issue_modrm = 0;
    b1.issue_attr = 0; b1.opnd_valid = 0; b1.opnd_data = 0;
    b1.res_accept = 0; b1.fwait_req = 0; b1.cpu_fpu_instr_ack = 0;
    b1.cpu_fpu_data_out = 0; b1.cpu_fpu_data_ready = 0;
    b1.cpu_fpu_busy = 0; b1.cpu_fpu_ready = 1; b1.cpu_fpu_exception = 0;
    b2.issue_valid = 0; b2.issue_opcode = 0; b2.issue_modrm = 0;
    b2.issue_attr = 0; b2.opnd_valid = 0; b2.opnd_data = 0;
    b2.res_accept = 0; b2.fwait_req = 0; b2.cpu_fpu_instr_ack = 0;
    b2.cpu_fpu_data_out = 0; b2.cpu_fpu_data_ready = 0;
    b2.cpu_fpu_busy = 0; b2.cpu_fpu_ready = 1; b2.cpu_fpu_exception = 0;
  endtask

  task automatic issue1(logic [7:0] op, logic [7:0] m, logic [5:0] a);
    q_instr.push_back(instr_exp(op, m, a));
    b1.issue_opcode = op;
    b1.issue_modrm  = m;
    b1.issue_attr   = a;
    b1.issue_valid  = 1;
    tick;
    b1.issue_valid  = 0;
  endtask

  task automatic ack1;
    int k = 0;
    while (!b1.cpu_fpu_instr_valid && k < 20) begin
      tick;
      k++;
    end
    chk("instr_valid_seen", 88'(b1.cpu_fpu_instr_valid), 88'd1);
    b1.cpu_fpu_instr_ack = 1;
    tick;
    b1.cpu_fpu_instr_ack = 0;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (b1.cpu_fpu_instr_valid && b1.cpu_fpu_instr_ack) begin
        if (q_instr.size() == 0) chk("instr_unexpected", 88'd1, 88'd0);
        else chk("instr_fields", instr_exp(b1.cpu_fpu_opcode,
                 b1.cpu_fpu_modrm, {1'b0, b1.cpu_fpu_is_bcd,
                 b1.cpu_fpu_is_integer, b1.cpu_fpu_operand_size,
                 b1.cpu_fpu_has_memory_op}), q_instr.pop_front());
      end
      if (b1.cpu_fpu_data_write) begin
        n_wr++;
        if (q_wr.size() == 0) chk("write_unexpected", 88'd1, 88'd0);
        else chk("write_data", 88'({b1.cpu_fpu_data_size,
                 b1.cpu_fpu_data_in}), q_wr.pop_front());
      end
      if (b1.cpu_fpu_data_read) n_rd++;
      if (b1.res_valid && b1.res_accept) begin
        if (q_res.size() == 0) chk("res_unexpected", 88'd1, 88'd0);
        else chk("res_data", 88'(b1.res_data), q_res.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ne, bad, wr0, rd0;
    zero_inputs();
    tick; tick;
    chk("rst_issue_ready", 88'(b1.issue_ready), 88'd1);
    chk("rst_outputs", 88'({b1.cpu_fpu_instr_valid, b1.res_valid,
        b1.seq_error, b1.cpu_fpu_wait, b1.cpu_fpu_data_write,
        b1.cpu_fpu_data_read}), 88'd0);
    chk("rst_data", 88'(b1.res_data | b1.cpu_fpu_data_in), 88'd0);
    reset_n = 1;
    tick;

    // Register-only op, ack on third valid cycle
    wr0 = n_wr; rd0 = n_rd; n = 0;
    issue1(8'hD8, 8'hC0, 6'b000000);
    for (int i = 0; i < 10 && b1.cpu_fpu_instr_valid; i++) begin
      n++;
      if (n == 3) b1.cpu_fpu_instr_ack = 1;
      tick;
      b1.cpu_fpu_instr_ack = 0;
    end
    chk("reg_valid_cycles", 88'(n >= 3 && n <= 4), 88'd1);
    chk("reg_no_strobes", 88'((n_wr - wr0) + (n_rd - rd0)), 88'd0);
    chk("reg_ready_back", 88'(b1.issue_ready), 88'd1);

    // Memory load of a 32-bit operand
    wr0 = n_wr;
    issue1(8'hD8, 8'h06, 6'b000011);
    q_wr.push_back(88'({3'd1, 80'h3F800000}));
    ack1();
    chk("load_in_opnd", 88'(b1.issue_ready), 88'd0);
    tick; tick;
    b1.opnd_data = 80'h3F800000; b1.opnd_valid = 1;
    tick;
    b1.opnd_valid = 0; b1.opnd_data = 0;
    tick; tick;
    chk("load_write_count", 88'(n_wr - wr0), 88'd1);
    chk("load_data_in", 88'(b1.cpu_fpu_data_in), 88'h3F800000);
    chk("load_ready_back", 88'(b1.issue_ready), 88'd1);

    // BCD operand forces data_size 4
    issue1(8'hDF, 8'h26, 6'b010001);
    q_wr.push_back(88'({3'd4, 80'h123456789ABC}));
    ack1();
    b1.opnd_data = 80'h123456789ABC; b1.opnd_valid = 1;
    tick;
    b1.opnd_valid = 0;
    tick; tick;

    // Store result through HOLD
    rd0 = n_rd;
    issue1(8'hD9, 8'h16, 6'b100000);
    q_res.push_back(88'(80'h3FFF8000000000000000));
    ack1();
    tick; tick;
    b1.cpu_fpu_data_out = 80'h3FFF8000000000000000;
    b1.cpu_fpu_data_ready = 1;
    tick;
    b1.cpu_fpu_data_ready = 0;
    tick;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (b1.res_valid) n++;
      tick;
    end
    chk("store_hold_cycles", 88'(n), 88'd5);
    chk("store_read_count", 88'(n_rd - rd0), 88'd1);
    b1.res_accept = 1;
    tick;
    b1.res_accept = 0;
    chk("store_done", 88'({b1.res_valid, b1.issue_ready}), 88'b01);

    // FWAIT held by busy FPU
    b1.cpu_fpu_busy = 1; b1.cpu_fpu_ready = 0;
    b1.fwait_req = 1;
    tick;
    b1.fwait_req = 0;
    n = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (b1.cpu_fpu_wait) n++;
      if (b1.issue_ready) bad++;
      tick;
    end
    chk("fwait_cycles", 88'(n), 88'd10);
    chk("fwait_ready_low", 88'(bad), 88'd0);
    b1.cpu_fpu_busy = 0; b1.cpu_fpu_ready = 1;
    tick;
    chk("fwait_exit", 88'({b1.cpu_fpu_wait, b1.issue_ready}), 88'b01);

    // Exception ends FWAIT
    b1.cpu_fpu_busy = 1; b1.cpu_fpu_ready = 0;
    b1.fwait_req = 1;
    tick;
    b1.fwait_req = 0;
    tick; tick;
    chk("fwait_exc_in", 88'(b1.cpu_fpu_wait), 88'd1);
    b1.cpu_fpu_exception = 1;
    tick;
    b1.cpu_fpu_exception = 0;
    chk("fwait_exc_exit", 88'({b1.cpu_fpu_wait, b1.issue_ready}), 88'b01);

    // issue_valid beats fwait_req
    b1.fwait_req = 1;
    issue1(8'hDA, 8'h01, 6'b001000);
    b1.fwait_req = 0;
    chk("prio_send", 88'({b1.cpu_fpu_instr_valid, b1.cpu_fpu_wait}), 88'b10);
    ack1();
    b1.cpu_fpu_busy = 0; b1.cpu_fpu_ready = 1;
    tick;

    // Ack timeout on the short-timeout instance
    b2.issue_opcode = 8'hDB; b2.issue_modrm = 8'h00; b2.issue_attr = 0;
    b2.issue_valid = 1;
    tick;
    b2.issue_valid = 0;
    n = 0; ne = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (b2.cpu_fpu_instr_valid) n++;
      if (b2.seq_error) begin
        ne++;
        if (!b2.issue_ready) bad++;
      end
      tick;
    end
    chk("to_valid_cycles", 88'(n), 88'd4);
    chk("to_error_pulses", 88'(ne), 88'd1);
    chk("to_error_in_idle", 88'(bad), 88'd0);

    // Operand wait never times out
    b2.issue_attr = 6'b000001; b2.issue_valid = 1;
    tick;
    b2.issue_valid = 0; b2.cpu_fpu_instr_ack = 1;
    tick;
    b2.cpu_fpu_instr_ack = 0;
    ne = 0;
    for (int i = 0; i < 10; i++) begin
      if (b2.seq_error) ne++;
      tick;
    end
    chk("opnd_no_timeout", 88'({ne[7:0], b2.issue_ready}), 88'd0);
    b2.opnd_valid = 1;
    tick;
    b2.opnd_valid = 0;
    tick;
    chk("opnd_done", 88'(b2.issue_ready), 88'd1);

    // Asynchronous reset during HOLD
    issue1(8'hDD, 8'h1E, 6'b100000);
    ack1();
    b1.cpu_fpu_data_out = 80'hABCD; b1.cpu_fpu_data_ready = 1;
    tick;
    b1.cpu_fpu_data_ready = 0;
    tick;
    chk("hold_before_rst", 88'(b1.res_valid), 88'd1);
    #2 reset_n = 0;
    #1;
    chk("rst_hold_outputs", 88'({b1.res_valid, b1.issue_ready}), 88'b01);
    chk("rst_hold_data", 88'({b1.res_data, b1.cpu_fpu_opcode}), 88'd0);
    tick;
    reset_n = 1;
    tick;

    chk("queues_empty", 88'(q_instr.size() + q_wr.size() + q_res.size()),
        88'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
